// File: rtl/mips_mc_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS controller.
interface mips_mc_control_if #(
    parameter int unsigned ALUCTRL_WIDTH = 4,
    parameter int unsigned CNT_WIDTH     = 16
);
    logic [5:0]               opcode;
    logic [5:0]               funct;
    logic                     zero;
    logic                     mem_ready;
    logic                     mem_req;
    logic                     IorD;
    logic                     MemWrite;
    logic                     IRWrite;
    logic                     DataWrite;
    logic                     RegDst;
    logic                     MemtoReg;
    logic                     RegWrite;
    logic                     RDx_FF_en;
    logic                     ALUOut_en;
    logic                     ALUSrcA;
    logic [1:0]               ALUSrcB;
    logic [ALUCTRL_WIDTH-1:0] ALUControl;
    logic [1:0]               PCSrc;
    logic                     PC_En;
    logic [3:0]               state;
    logic                     illegal_op;
    logic [CNT_WIDTH-1:0]     instr_count;

    // Controller side
    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, IorD, MemWrite, IRWrite, DataWrite, RegDst, MemtoReg,
               RegWrite, RDx_FF_en, ALUOut_en, ALUSrcA, ALUSrcB, ALUControl,
               PCSrc, PC_En, state, illegal_op, instr_count
    );

    // Datapath side
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, IorD, MemWrite, IRWrite, DataWrite, RegDst, MemtoReg,
               RegWrite, RDx_FF_en, ALUOut_en, ALUSrcA, ALUSrcB, ALUControl,
               PCSrc, PC_En, state, illegal_op, instr_count
    );
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM with memory wait states,
// illegal-instruction trap and a retired-instruction counter.
module mips_mc_control #(
    parameter bit          MEM_WAIT_EN   = 1'b1,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned ALUCTRL_WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    mips_mc_control_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXE  = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e               state_q, state_d;
    logic                 is_sw_q, is_sw_d;
    logic                 is_bne_q, is_bne_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 ready;
    logic                 fn_ok;
    logic [3:0]           fn_alu;

    assign ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    // R-type funct to ALU operation; fn_ok flags a supported funct
    always_comb begin
        fn_ok  = 1'b1;
        fn_alu = ALU_AND;
        case (bus.funct)
            6'b100000: fn_alu = ALU_ADD;
            6'b100010: fn_alu = ALU_SUB;
            6'b100100: fn_alu = ALU_AND;
            6'b100101: fn_alu = ALU_OR;
            6'b101010: fn_alu = ALU_SLT;
            6'b100111: fn_alu = ALU_NOR;
            default:   fn_ok  = 1'b0;
        endcase
    end

    // State, latched instruction flavour and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            is_sw_q  <= 1'b0;
            is_bne_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            is_sw_q  <= is_sw_d;
            is_bne_q <= is_bne_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; opcode flavour is captured in DECODE so later states ignore the IR bus
    always_comb begin
        state_d  = state_q;
        is_sw_d  = is_sw_q;
        is_bne_d = is_bne_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (ready) state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d  = (bus.opcode == OP_SW);
                is_bne_d = (bus.opcode == OP_BNE);
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDIEXE;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = is_sw_q ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state_d = S_MEMWB;
            S_MEMWRITE: begin
                if (ready) begin
                    state_d = S_FETCH;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_EXECUTE:  state_d = fn_ok ? S_ALUWB : S_TRAP;
            S_ADDIEXE:  state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_d = S_FETCH;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
            end
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath controls decoded from the current state
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.DataWrite  = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.RDx_FF_en  = 1'b0;
        bus.ALUOut_en  = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = '0;
        bus.PCSrc      = 2'b00;
        bus.PC_En      = 1'b0;
        bus.illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req    = 1'b1;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = ALUCTRL_WIDTH'(ALU_ADD);
                bus.IRWrite    = ready;
                bus.PC_En      = ready;
            end
            S_DECODE: begin
                bus.RDx_FF_en  = 1'b1;
                bus.ALUSrcB    = 2'b11;
                bus.ALUControl = ALUCTRL_WIDTH'(ALU_ADD);
                bus.ALUOut_en  = 1'b1;
            end
            S_MEMADR, S_ADDIEXE: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = ALUCTRL_WIDTH'(ALU_ADD);
                bus.ALUOut_en  = 1'b1;
            end
            S_MEMREAD: begin
                bus.mem_req   = 1'b1;
                bus.IorD      = 1'b1;
                bus.DataWrite = ready;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                bus.mem_req  = 1'b1;
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUOut_en  = 1'b1;
                bus.ALUControl = fn_ok ? ALUCTRL_WIDTH'(fn_alu) : '0;
            end
            S_ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = ALUCTRL_WIDTH'(ALU_SUB);
                bus.PCSrc      = 2'b01;
                bus.PC_En      = is_bne_q ? ~bus.zero : bus.zero;
            end
            S_ADDIWB:   bus.RegWrite   = 1'b1;
            S_JUMP: begin
                bus.PCSrc = 2'b10;
                bus.PC_En = 1'b1;
            end
            S_TRAP:     bus.illegal_op = 1'b1;
            default: ;
        endcase
    end

    assign bus.state       = 4'(state_q);
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized scoreboard bench for mips_mc_control (4-bit counter to exercise wrap).
module tb_mips_mc_control;
    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND_ = 4'b0000,
                           OR_ = 4'b0001, SLT = 4'b0111, NOR_ = 4'b1100;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, iord, memwrite, irwrite, datawrite, regdst, memtoreg,
                    regwrite, rdx, aluout_en, alusrca;
        logic [1:0] alusrcb;
        logic [3:0] aluctl;
        logic [1:0] pcsrc;
        logic       pc_en, illegal;
        logic [3:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mips_mc_control_if #(.ALUCTRL_WIDTH(4), .CNT_WIDTH(4)) bus ();

    mips_mc_control #(.MEM_WAIT_EN(1'b1), .CNT_WIDTH(4), .ALUCTRL_WIDTH(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc_no = 0;
    logic [3:0] cnt    = 4'd0;

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    function automatic exp_t base(input logic [3:0] st);
        exp_t e = '0;
        e.st  = st;
        e.cnt = cnt;
        return e;
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return ADD;
            6'b100010: return SUB;
            6'b100100: return AND_;
            6'b100101: return OR_;
            6'b101010: return SLT;
            6'b100111: return NOR_;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic fn_legal(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                          6'b001000, 6'b000010};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected during that cycle
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic mr, input logic rst, input exp_t e);
        @(negedge clk);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = mr;
        reset         = rst;
        sb.push_back(e);
    endtask

    task automatic step(input exp_t e);
        cyc(r6(), r6(), r1(), r1(), 1'b1, e);
    endtask

    task automatic retire();
        cnt = cnt + 4'd1;
    endtask

    task automatic do_reset(input int n);
        cnt = 4'd0;
        for (int i = 0; i < n; i++) cyc(r6(), r6(), r1(), r1(), 1'b0, base(4'd0));
        step(base(4'd0));
    endtask

    task automatic fetch(input int w);
        exp_t e = base(4'd1);
        e.mem_req = 1'b1; e.alusrcb = 2'b01; e.aluctl = ADD;
        for (int i = 0; i < w; i++) cyc(r6(), r6(), r1(), 1'b0, 1'b1, e);
        e.irwrite = 1'b1; e.pc_en = 1'b1;
        cyc(r6(), r6(), r1(), 1'b1, 1'b1, e);
    endtask

    task automatic decode(input logic [5:0] op);
        exp_t e = base(4'd2);
        e.rdx = 1'b1; e.alusrcb = 2'b11; e.aluctl = ADD; e.aluout_en = 1'b1;
        cyc(op, r6(), r1(), r1(), 1'b1, e);
    endtask

    task automatic trap_hold(input int n);
        exp_t e = base(4'd13);
        e.illegal = 1'b1;
        for (int i = 0; i < n; i++) step(e);
    endtask

    // One instruction: kind 0=R 1=lw 2=sw 3=beq 4=bne 5=addi 6=j
    task automatic instr(input int kind, input int wf, input int wm, input logic z,
                         input logic [5:0] fn);
        exp_t e;
        logic [5:0] op;
        case (kind)
            0: op = 6'b000000; 1: op = 6'b100011; 2: op = 6'b101011;
            3: op = 6'b000100; 4: op = 6'b000101; 5: op = 6'b001000;
            default: op = 6'b000010;
        endcase
        fetch(wf);
        decode(op);
        case (kind)
            0: begin
                e = base(4'd7); e.alusrca = 1'b1; e.aluout_en = 1'b1; e.aluctl = alu_of(fn);
                cyc(r6(), fn, r1(), r1(), 1'b1, e);
                if (fn_legal(fn)) begin
                    e = base(4'd8); e.regdst = 1'b1; e.regwrite = 1'b1;
                    step(e); retire();
                end
            end
            1, 2: begin
                e = base(4'd3); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluctl = ADD;
                e.aluout_en = 1'b1;
                step(e);
                e = base(kind == 1 ? 4'd4 : 4'd6); e.mem_req = 1'b1; e.iord = 1'b1;
                e.memwrite = (kind == 2);
                for (int i = 0; i < wm; i++) cyc(r6(), r6(), r1(), 1'b0, 1'b1, e);
                e.datawrite = (kind == 1);
                cyc(r6(), r6(), r1(), 1'b1, 1'b1, e);
                if (kind == 1) begin
                    e = base(4'd5); e.memtoreg = 1'b1; e.regwrite = 1'b1;
                    step(e);
                end
                retire();
            end
            3, 4: begin
                e = base(4'd9); e.alusrca = 1'b1; e.aluctl = SUB; e.pcsrc = 2'b01;
                e.pc_en = (kind == 3) ? z : ~z;
                cyc(r6(), r6(), z, r1(), 1'b1, e);
                retire();
            end
            5: begin
                e = base(4'd10); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluctl = ADD;
                e.aluout_en = 1'b1;
                step(e);
                e = base(4'd11); e.regwrite = 1'b1;
                step(e); retire();
            end
            default: begin
                e = base(4'd12); e.pcsrc = 2'b10; e.pc_en = 1'b1;
                step(e); retire();
            end
        endcase
    endtask

    function automatic logic [5:0] rand_legal_fn();
        case ($urandom_range(0, 5))
            0: return 6'b100000; 1: return 6'b100010; 2: return 6'b100100;
            3: return 6'b100101; 4: return 6'b101010; default: return 6'b100111;
        endcase
    endfunction

    // Monitor: compare DUT outputs with the queued expectation each cycle
    initial begin
        exp_t act, exp;
        forever begin
            @(negedge clk);
            #2;
            cyc_no++;
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                act = '{st: bus.state, mem_req: bus.mem_req, iord: bus.IorD,
                        memwrite: bus.MemWrite, irwrite: bus.IRWrite,
                        datawrite: bus.DataWrite, regdst: bus.RegDst,
                        memtoreg: bus.MemtoReg, regwrite: bus.RegWrite,
                        rdx: bus.RDx_FF_en, aluout_en: bus.ALUOut_en,
                        alusrca: bus.ALUSrcA, alusrcb: bus.ALUSrcB,
                        aluctl: bus.ALUControl, pcsrc: bus.PCSrc, pc_en: bus.PC_En,
                        illegal: bus.illegal_op, cnt: bus.instr_count};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL cycle%0d: state got %0d want %0d, count got %0d want %0d, vector got %h want %h",
                             cyc_no, act.st, exp.st, act.cnt, exp.cnt, act, exp);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, limit 200000", $time);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        do_reset(3);

        // Directed: fetch stall, R-add, delayed lw, beq/bne, 16 jumps for wrap
        instr(0, 3, 0, 1'b0, 6'b100000);
        instr(1, 0, 3, 1'b0, 6'b0);
        instr(2, 1, 2, 1'b0, 6'b0);
        instr(3, 0, 0, 1'b1, 6'b0);
        instr(4, 0, 0, 1'b1, 6'b0);
        for (int i = 0; i < 16; i++) instr(6, 0, 0, 1'b0, 6'b0);

        // Randomized legal instruction stream
        for (int i = 0; i < 150; i++)
            instr($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3),
                  r1(), rand_legal_fn());

        // Illegal opcode 111111, then a random illegal one
        fetch(0); decode(6'b111111); trap_hold(10); do_reset(2);
        instr(5, 0, 0, 1'b0, 6'b0);
        do op = r6(); while (op_legal(op));
        fetch(1); decode(op); trap_hold(5); do_reset(1);

        // Illegal funct 000001, then a random illegal one
        instr(0, 0, 0, 1'b0, 6'b000001); trap_hold(10); do_reset(2);
        do fn = r6(); while (fn_legal(fn));
        instr(0, 2, 0, 1'b0, fn); trap_hold(3); do_reset(1);

        // Reset during a stalled load, with mem_ready arriving together with reset
        instr(6, 0, 0, 1'b0, 6'b0);
        begin
            exp_t e;
            fetch(0); decode(6'b100011);
            e = base(4'd3); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluctl = ADD;
            e.aluout_en = 1'b1;
            step(e);
            e = base(4'd4); e.mem_req = 1'b1; e.iord = 1'b1;
            cyc(r6(), r6(), r1(), 1'b0, 1'b1, e);
            cnt = 4'd0;
            cyc(r6(), r6(), r1(), 1'b1, 1'b0, base(4'd0));
            do_reset(1);
        end

        for (int i = 0; i < 30; i++)
            instr($urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 2),
                  r1(), rand_legal_fn());

        @(negedge clk);
        #5;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Parametrised multi-cycle MIPS control unit; the next-generation successor to the current ControlUnit.
- Registered Moore FSM that drives every datapath enable/select of the multi-cycle MIPS core.
- New over the previous generation: bne/addi/jump support, a memory wait-state handshake, illegal-instruction trap, and a retired-instruction counter.

Parameters:
MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready=1; 0 = mem_ready ignored (single-cycle memory)
CNT_WIDTH, 16, width of retired-instruction counter
ALUCTRL_WIDTH, 4, width of ALUControl (values below are zero-extended if larger)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  memory access complete this cycle
mem_req  output  1  memory access in progress
IorD  output  1  0=PC address, 1=ALUOut address
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register load
DataWrite  output  1  data register load
RegDst  output  1  0=rt, 1=rd
MemtoReg  output  1  0=ALUOut, 1=data register
RegWrite  output  1  register file write enable
RDx_FF_en  output  1  A/B operand register load
ALUOut_en  output  1  ALUOut register load
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=signext, 11=signext<<2
ALUControl  output  ALUCTRL_WIDTH  ALU operation
PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
PC_En  output  1  PC register load
state  output  4  current FSM state encoding
illegal_op  output  1  high while in TRAP
instr_count  output  CNT_WIDTH  retired instructions, wraps

Behaviour:
- ALU codes: ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111, NOR=1100.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, ALUWB=8, BRANCH=9, ADDIEXE=10, ADDIWB=11, JUMP=12, TRAP=13.
- Reset: while reset=0, state=IDLE, instr_count=0 and every output=0. IDLE drives all outputs 0; IDLE->FETCH unconditionally on the next edge.
- Outputs not listed for a state are 0.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00.
  - IRWrite, PC_En and advance to DECODE only when ready is true.
  - ready = mem_ready if MEM_WAIT_EN=1, else 1.
  - Otherwise hold in FETCH with IRWrite=PC_En=0.
- DECODE: RDx_FF_en=1, ALUSrcA=0, ALUSrcB=11, ADD, ALUOut_en=1 (branch target). Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEMADR
  - 000100 or 000101 -> BRANCH
  - 001000 -> ADDIEXE
  - 000010 -> JUMP
  - any other opcode -> TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD, ALUOut_en=1. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: mem_req=1, IorD=1, DataWrite=ready; advance to MEMWB on ready, else hold.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
- MEMWRITE: mem_req=1, IorD=1, MemWrite=1 held until ready; -> FETCH on ready.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOut_en=1; ALUControl from funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR
  - any other funct -> TRAP instead of ALUWB
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01. PC_En=zero for beq, ~zero for bne. -> FETCH.
- ADDIEXE: ALUSrcA=1, ALUSrcB=10, ADD, ALUOut_en=1; -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; -> FETCH.
- JUMP: PCSrc=10, PC_En=1; -> FETCH.
- TRAP: illegal_op=1, all other controls 0; absorbing until reset.
- instr_count: +1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB or JUMP. Not incremented from IDLE. Wraps from all-ones to 0.
- opcode/funct are sampled in DECODE/EXECUTE only; changes in other states are ignored.
- Reset mid-access: controls drop to 0 asynchronously. A pending mem_ready is ignored.

Test Plan:
- Reset then 3 cycles, MEM_WAIT_EN=1, mem_ready held 0 -> state IDLE->FETCH->FETCH; IRWrite=PC_En=0, mem_req=1.
- R-type add (opcode 0, funct 100000), mem_ready=1 -> states 1,2,7,8,1; ALUControl=0010 in EXECUTE; RegWrite=1, RegDst=1 in ALUWB; instr_count 0->1.
- lw with mem_ready delayed 3 cycles in MEMREAD -> MEMREAD held 3 cycles with DataWrite=0, then DataWrite=1 for one cycle; MEMWB asserts MemtoReg=1, RegWrite=1.
- beq with zero=1 then bne with zero=1 -> PC_En=1, PCSrc=01 for beq; PC_En=0 for bne; both retire (count +2).
- Opcode 111111 in DECODE; separately R-type funct 000001 -> TRAP, illegal_op=1 held 10 cycles; reset=0 returns to IDLE with outputs 0.
- CNT_WIDTH=4, 16 jump instructions (opcode 000010) -> PC_En=1, PCSrc=10 each; instr_count wraps 15->0.
